// File: rtl/mux4_arbiter.sv
// Round-robin arbiter for a shared 4:1 datapath mux: grants one master at a time,
// drives the mux select, registers the selected data and enforces a hold limit.
module mux4_arbiter #(
  parameter int size     = 32,
  parameter int MAX_HOLD = 15
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [3:0]      req_i,
  input  logic            done_i,
  input  logic [size-1:0] data0_i,
  input  logic [size-1:0] data1_i,
  input  logic [size-1:0] data2_i,
  input  logic [size-1:0] data3_i,
  output logic [3:0]      grant_o,
  output logic [1:0]      select_o,
  output logic [size-1:0] data_o,
  output logic            valid_o,
  output logic            busy_o,
  output logic            timeout_o
);

  // hold_cnt only ever reaches MAX_HOLD-1 before a forced release.
  localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

  // Handshake: req_i is a level held by a master for as long as it wants the
  // mux; grant_o/select_o answer one edge later; done_i is only honoured while
  // busy_o=1; data_o is valid exactly when valid_o=1.

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state;
  logic [1:0]      ptr;
  logic [HW-1:0]   hold_cnt;

  logic            own_req;
  logic            hold_hit;
  logic            release_c;
  logic            timeout_c;
  logic [1:0]      start_c;
  logic            win_c;
  logic [1:0]      win_idx;
  logic [size-1:0] sel_data;

  // Rotating priority scan: first requester at or above start, modulo 4.
  function automatic logic [2:0] pick(input logic [3:0] req, input logic [1:0] start);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (req[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  always_comb begin
    own_req   = req_i[select_o];
    hold_hit  = (MAX_HOLD > 0) && (hold_cnt == HOLD_LAST);
    release_c = done_i || !own_req || hold_hit;
    timeout_c = hold_hit && !done_i && own_req;
    start_c   = (state == GRANT) ? (select_o + 2'd1) : ptr;
    {win_c, win_idx} = pick(req_i, start_c);
  end

  always_comb begin
    sel_data = data0_i;
    case (select_o)
      2'd0: sel_data = data0_i;
      2'd1: sel_data = data1_i;
      2'd2: sel_data = data2_i;
      2'd3: sel_data = data3_i;
      default: sel_data = data0_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      hold_cnt  <= '0;
      grant_o   <= 4'b0000;
      select_o  <= 2'd0;
      data_o    <= '0;
      valid_o   <= 1'b0;
      busy_o    <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid_o   <= 1'b0;
          timeout_o <= 1'b0;
          if (win_c) begin
            state    <= GRANT;
            busy_o   <= 1'b1;
            grant_o  <= 4'b0001 << win_idx;
            select_o <= win_idx;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          data_o    <= sel_data;
          valid_o   <= 1'b1;
          timeout_o <= release_c && timeout_c;
          if (release_c) begin
            ptr <= select_o + 2'd1;
            if (win_c) begin
              // Handover without an idle bubble; the releaser was scanned last.
              grant_o  <= 4'b0001 << win_idx;
              select_o <= win_idx;
              hold_cnt <= '0;
            end else begin
              state   <= IDLE;
              busy_o  <= 1'b0;
              grant_o <= 4'b0000;
            end
          end else if (MAX_HOLD > 0) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          busy_o  <= 1'b0;
          grant_o <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_arbiter.sv
// Bench for mux4_arbiter: directed scenarios plus random traffic, all checked
// against an owner/ptr/cycles-held model of the arbitration rules.
module tb_mux4_arbiter;
  localparam int W    = 32;
  localparam int HOLD = 4;

  logic          clk;
  logic          rst;
  logic [3:0]    req;
  logic          done;
  logic [W-1:0]  d0, d1, d2, d3;
  logic [3:0]    grant;
  logic [1:0]    sel;
  logic [W-1:0]  data;
  logic          valid, busy, timeout;

  int checks;
  int errors;

  // Reference model: owner = -1 means nobody holds the mux.
  int           m_owner;
  int           m_ptr;
  int           m_held;
  int           m_select;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_timeout;

  mux4_arbiter #(.size(W), .MAX_HOLD(HOLD)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .done_i(done),
    .data0_i(d0), .data1_i(d1), .data2_i(d2), .data3_i(d3),
    .grant_o(grant), .select_o(sel), .data_o(data),
    .valid_o(valid), .busy_o(busy), .timeout_o(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int first_req(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] bus_of(input int n);
    case (n)
      0: return d0;
      1: return d1;
      2: return d2;
      default: return d3;
    endcase
  endfunction

  function automatic logic [3:0] exp_grant();
    logic [3:0] g;
    g = 4'b0000;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_held = 0; m_select = 0;
    m_data = '0; m_valid = 1'b0; m_timeout = 1'b0;
  endtask

  // Advances the model by the edge about to happen, using the current inputs.
  task automatic model_tick();
    int  win;
    bit  limit, rel;
    m_timeout = 1'b0;
    if (m_owner < 0) begin
      m_valid = 1'b0;
      win = first_req(req, m_ptr);
      if (win >= 0) begin m_owner = win; m_select = win; m_held = 1; end
    end else begin
      m_data  = bus_of(m_owner);
      m_valid = 1'b1;
      limit   = (HOLD > 0) && (m_held == HOLD);
      rel     = done || !req[m_owner] || limit;
      if (rel) begin
        m_timeout = limit && !done && req[m_owner];
        m_ptr = (m_owner + 1) % 4;
        win = first_req(req, m_ptr);
        if (win >= 0) begin m_owner = win; m_select = win; m_held = 1; end
        else m_owner = -1;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic step();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; req = 4'b0000; done = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_select: got %0d expected 0", sel); end
    checks++; if (data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", data); end
    checks++; if ({valid, busy, timeout} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {valid, busy, timeout}); end
    d2 = 32'h1234_5678;
    req = 4'b0100;
    step();
    step();
    checks++; if (grant !== 4'b0100 || data !== 32'h1234_5678) begin errors++; $display("FAIL reset_pre_grant: got %b/%h expected 0100/12345678", grant, data); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({grant, sel, data, valid, busy, timeout} !== '0) begin errors++; $display("FAIL reset_async_clear: got %b %0d %h %b%b%b expected all zero", grant, sel, data, valid, busy, timeout); end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    req = 4'b1010;
    step();
    checks++; if (grant !== 4'b0010 || sel !== 2'd1) begin errors++; $display("FAIL reset_first_grant: got %b/%0d expected 0010/1", grant, sel); end
  endtask

  task automatic test_single();
    do_reset();
    d2 = 32'h0000_00A5;
    req = 4'b0100;
    step();
    checks++; if (grant !== 4'b0100 || sel !== 2'd2 || busy !== 1'b1) begin errors++; $display("FAIL single_grant: got %b/%0d/%b expected 0100/2/1", grant, sel, busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_valid_early: got %b expected 0", valid); end
    step();
    checks++; if (data !== 32'hA5 || valid !== 1'b1) begin errors++; $display("FAIL single_data: got %h/%b expected a5/1", data, valid); end
    req = 4'b0000; done = 1'b1;
    step();
    checks++; if (grant !== 4'b0000 || sel !== 2'd2 || busy !== 1'b0 || valid !== 1'b1) begin errors++; $display("FAIL single_release: got %b/%0d/%b/%b expected 0000/2/0/1", grant, sel, busy, valid); end
    done = 1'b0;
    step();
    checks++; if (valid !== 1'b0 || data !== 32'hA5) begin errors++; $display("FAIL single_valid_drop: got %b/%h expected 0/a5", valid, data); end
  endtask

  task automatic test_rotation();
    logic [1:0] exp_q[$];
    logic [1:0] e;
    do_reset();
    d0 = 32'h100; d1 = 32'h101; d2 = 32'h102; d3 = 32'h103;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    req = 4'b1111; done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      e = exp_q.pop_front();
      checks++; if (sel !== e || grant !== exp_grant()) begin errors++; $display("FAIL rotation_select[%0d]: got %0d/%b expected %0d/%b", i, sel, grant, e, exp_grant()); end
      if (i > 0) begin
        checks++; if (valid !== 1'b1 || data !== m_data) begin errors++; $display("FAIL rotation_data[%0d]: got %b/%h expected 1/%h", i, valid, data, m_data); end
      end
    end
    done = 1'b0;
  endtask

  task automatic test_hold_limit();
    int pulses;
    do_reset();
    pulses = 0;
    req = 4'b0010;
    for (int i = 1; i <= 13; i++) begin
      step();
      if (timeout) pulses++;
      checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL hold_grant[%0d]: got %b expected 0010", i, grant); end
      checks++; if (timeout !== m_timeout) begin errors++; $display("FAIL hold_timeout[%0d]: got %b expected %b", i, timeout, m_timeout); end
    end
    checks++; if (pulses != 3) begin errors++; $display("FAIL hold_pulse_count: got %0d expected 3", pulses); end
  endtask

  task automatic test_req_drop();
    do_reset();
    req = 4'b1001;
    step();
    checks++; if (grant !== 4'b0001 || sel !== 2'd0) begin errors++; $display("FAIL drop_first: got %b/%0d expected 0001/0", grant, sel); end
    req = 4'b1000;
    step();
    checks++; if (grant !== 4'b1000 || sel !== 2'd3 || valid !== 1'b1) begin errors++; $display("FAIL drop_handover: got %b/%0d/%b expected 1000/3/1", grant, sel, valid); end
  endtask

  task automatic test_done_timeout();
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 4; i++) step();
    done = 1'b1; req = 4'b0011;
    step();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL done_timeout_pulse: got %b expected 0", timeout); end
    checks++; if (grant !== 4'b0010 || sel !== 2'd1) begin errors++; $display("FAIL done_timeout_ptr: got %b/%0d expected 0010/1", grant, sel); end
    done = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req  = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 3) == 0);
      d0 = $urandom; d1 = $urandom; d2 = $urandom; d3 = $urandom;
      step();
      checks++; if (grant !== exp_grant() || sel !== 2'(m_select)) begin errors++; $display("FAIL rand_grant[%0d]: got %b/%0d expected %b/%0d", i, grant, sel, exp_grant(), m_select); end
      checks++; if (valid !== m_valid || (m_valid && data !== m_data)) begin errors++; $display("FAIL rand_data[%0d]: got %b/%h expected %b/%h", i, valid, data, m_valid, m_data); end
      checks++; if (busy !== (m_owner >= 0) || timeout !== m_timeout) begin errors++; $display("FAIL rand_flags[%0d]: got %b%b expected %b%b", i, busy, timeout, m_owner >= 0, m_timeout); end
    end
    req = 4'b0000; done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; req = 4'b0000; done = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    model_reset();
    test_reset();
    test_single();
    test_rotation();
    test_hold_limit();
    test_req_drop();
    test_done_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
